// File: rtl/saturating_up_down_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : saturating_up_down_counter                                      |
// | Purpose  : Up/down counter over 0..WIDTH-1 that saturates at both ends.     |
// |            Building block for confidence counters, credit/occupancy         |
// |            trackers and hysteresis filters.                                 |
// | Options  : SATURATING_COUNTER_FLAGS_EN adds the is_min / is_max decodes.    |
// | Revision : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module saturating_up_down_counter #(
  parameter int WIDTH = 4,
  parameter int RESET = 0
) (
  input  logic                         clock,
  input  logic                         resetn,
  input  logic                         increment,
  input  logic                         decrement,
  output logic [$clog2(WIDTH)-1:0]     count
`ifdef SATURATING_COUNTER_FLAGS_EN
  ,
  output logic                         is_min,
  output logic                         is_max
`endif
);

  localparam int WIDTH_LOG2 = $clog2(WIDTH);

  // Bounds are expressed against WIDTH-1 rather than all-ones so that
  // non-power-of-two ranges never reach the unused upper encodings.
  localparam logic [WIDTH_LOG2-1:0] C_MIN   = '0;
  localparam logic [WIDTH_LOG2-1:0] C_MAX   = WIDTH_LOG2'(WIDTH - 1);
  localparam logic [WIDTH_LOG2-1:0] C_ONE   = WIDTH_LOG2'(1);
  localparam logic [WIDTH_LOG2-1:0] C_RESET = WIDTH_LOG2'(RESET);

  logic [WIDTH_LOG2-1:0] r_count;
  logic [WIDTH_LOG2-1:0] w_count_next;
  logic                  w_at_min;
  logic                  w_at_max;
  logic                  w_step_up;
  logic                  w_step_down;

  assign w_at_min = (r_count == C_MIN);
  assign w_at_max = (r_count == C_MAX);

  // Opposing requests cancel; a request pushing past a bound is dropped.
  assign w_step_up   = increment & ~decrement & ~w_at_max;
  assign w_step_down = decrement & ~increment & ~w_at_min;

  // Next-count selection; the guards above make the arithmetic overflow-free.
  always_comb begin
    w_count_next = r_count;
    if (w_step_up) begin
      w_count_next = r_count + C_ONE;
    end else if (w_step_down) begin
      w_count_next = r_count - C_ONE;
    end
  end

  // Count register with immediate (asynchronous) return to the reset value.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_count <= C_RESET;
    end else begin
      r_count <= w_count_next;
    end
  end

  assign count = r_count;

`ifdef SATURATING_COUNTER_FLAGS_EN
  // Bound flags decode the registered count directly, so they add no latency.
  assign is_min = w_at_min;
  assign is_max = w_at_max;
`endif

endmodule
`default_nettype wire

// File: tb/tb_saturating_up_down_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_saturating_up_down_counter                                   |
// | Purpose  : Directed and randomised self-checking bench for                  |
// |            saturating_up_down_counter (WIDTH=4/RESET=0, WIDTH=4/RESET=2,    |
// |            WIDTH=5/RESET=0 instances sharing one stimulus stream).          |
// | Options  : SATURATING_COUNTER_FLAGS_EN also checks is_min / is_max.         |
// | Revision : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_saturating_up_down_counter;

  logic       clock;
  logic       resetn;
  logic       increment;
  logic       decrement;
  logic [1:0] count4;
  logic [1:0] countr;
  logic [2:0] count5;
`ifdef SATURATING_COUNTER_FLAGS_EN
  logic       is_min4, is_max4, is_minr, is_maxr, is_min5, is_max5;
`endif

  int errors;
  int checks;

  saturating_up_down_counter #(.WIDTH(4), .RESET(0)) dut4 (
    .clock(clock), .resetn(resetn), .increment(increment), .decrement(decrement),
    .count(count4)
`ifdef SATURATING_COUNTER_FLAGS_EN
    , .is_min(is_min4), .is_max(is_max4)
`endif
  );

  saturating_up_down_counter #(.WIDTH(4), .RESET(2)) dutr (
    .clock(clock), .resetn(resetn), .increment(increment), .decrement(decrement),
    .count(countr)
`ifdef SATURATING_COUNTER_FLAGS_EN
    , .is_min(is_minr), .is_max(is_maxr)
`endif
  );

  saturating_up_down_counter #(.WIDTH(5), .RESET(0)) dut5 (
    .clock(clock), .resetn(resetn), .increment(increment), .decrement(decrement),
    .count(count5)
`ifdef SATURATING_COUNTER_FLAGS_EN
    , .is_min(is_min5), .is_max(is_max5)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Apply one request pair, let one rising edge pass, return on the falling edge.
  task automatic tick(input logic inc, input logic dec);
    increment = inc;
    decrement = dec;
    @(negedge clock);
  endtask

  // Brief reset pulse that starts and ends between rising edges.
  task automatic pulse_reset();
    increment = 1'b0;
    decrement = 1'b0;
    #1 resetn = 1'b0;
    #1 resetn = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_reset();
    increment = 1'b0;
    decrement = 1'b0;
    #2 resetn = 1'b0;
    #1;
    checks += 3;
    if (count4 !== 2'd0) begin errors++; $display("FAIL reset_async_w4: got %0d expected 0", count4); end
    if (countr !== 2'd2) begin errors++; $display("FAIL reset_async_r2: got %0d expected 2", countr); end
    if (count5 !== 3'd0) begin errors++; $display("FAIL reset_async_w5: got %0d expected 0", count5); end
    @(negedge clock);
    resetn = 1'b1;
    @(negedge clock);
    checks++;
    if (count4 !== 2'd0) begin errors++; $display("FAIL reset_release_w4: got %0d expected 0", count4); end
`ifdef SATURATING_COUNTER_FLAGS_EN
    checks += 3;
    if (is_min4 !== 1'b1) begin errors++; $display("FAIL reset_is_min: got %0b expected 1", is_min4); end
    if (is_max4 !== 1'b0) begin errors++; $display("FAIL reset_is_max: got %0b expected 0", is_max4); end
    if (is_minr !== 1'b0) begin errors++; $display("FAIL reset_r2_is_min: got %0b expected 0", is_minr); end
`endif
  endtask

  task automatic test_increment();
    logic [1:0] exp_cnt [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    for (int k = 0; k < 5; k++) begin
      tick(1'b1, 1'b0);
      checks++;
      if (count4 !== exp_cnt[k])
        begin errors++; $display("FAIL increment_step%0d: got %0d expected %0d", k, count4, exp_cnt[k]); end
`ifdef SATURATING_COUNTER_FLAGS_EN
      checks++;
      if (is_max4 !== (k >= 2))
        begin errors++; $display("FAIL increment_is_max%0d: got %0b expected %0b", k, is_max4, (k >= 2)); end
`endif
    end
  endtask

  task automatic test_decrement();
    logic [1:0] exp_cnt [5] = '{2'd2, 2'd1, 2'd0, 2'd0, 2'd0};
    for (int k = 0; k < 5; k++) begin
      tick(1'b0, 1'b1);
      checks++;
      if (count4 !== exp_cnt[k])
        begin errors++; $display("FAIL decrement_step%0d: got %0d expected %0d", k, count4, exp_cnt[k]); end
`ifdef SATURATING_COUNTER_FLAGS_EN
      checks++;
      if (is_min4 !== (k >= 2))
        begin errors++; $display("FAIL decrement_is_min%0d: got %0b expected %0b", k, is_min4, (k >= 2)); end
`endif
    end
  endtask

  task automatic test_simultaneous();
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    checks++;
    if (count4 !== 2'd2) begin errors++; $display("FAIL simul_setup: got %0d expected 2", count4); end
    for (int k = 0; k < 3; k++) begin
      tick(1'b1, 1'b1);
      checks++;
      if (count4 !== 2'd2)
        begin errors++; $display("FAIL simul_hold%0d: got %0d expected 2", k, count4); end
    end
  endtask

  task automatic test_async_reset();
    pulse_reset();
    tick(1'b1, 1'b0);
    checks++;
    if (countr !== 2'd3) begin errors++; $display("FAIL async_countup: got %0d expected 3", countr); end
    increment = 1'b0;
    #2 resetn = 1'b0;
    #1;
    checks += 2;
    if (countr !== 2'd2) begin errors++; $display("FAIL async_midcount_r2: got %0d expected 2", countr); end
    if (count4 !== 2'd0) begin errors++; $display("FAIL async_midcount_w4: got %0d expected 0", count4); end
    increment = 1'b1;
    @(negedge clock);
    checks++;
    if (countr !== 2'd2) begin errors++; $display("FAIL async_held_in_reset: got %0d expected 2", countr); end
    resetn = 1'b1;
    tick(1'b1, 1'b0);
    checks += 2;
    if (countr !== 2'd3) begin errors++; $display("FAIL async_release_r2: got %0d expected 3", countr); end
    if (count4 !== 2'd1) begin errors++; $display("FAIL async_release_w4: got %0d expected 1", count4); end
  endtask

  task automatic test_width5();
    logic [2:0] exp_up [6] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd4};
    logic [2:0] exp_dn [6] = '{3'd3, 3'd2, 3'd1, 3'd0, 3'd0, 3'd0};
    pulse_reset();
    for (int k = 0; k < 6; k++) begin
      tick(1'b1, 1'b0);
      checks++;
      if (count5 !== exp_up[k])
        begin errors++; $display("FAIL w5_up%0d: got %0d expected %0d", k, count5, exp_up[k]); end
    end
    for (int k = 0; k < 6; k++) begin
      tick(1'b0, 1'b1);
      checks++;
      if (count5 !== exp_dn[k])
        begin errors++; $display("FAIL w5_down%0d: got %0d expected %0d", k, count5, exp_dn[k]); end
    end
  endtask

  task automatic test_random();
    int   m4, mr, m5;
    logic inc, dec;
    pulse_reset();
    m4 = 0;
    mr = 2;
    m5 = 0;
    for (int n = 0; n < 100; n++) begin
      inc = 1'($urandom_range(0, 1));
      dec = 1'($urandom_range(0, 1));
      if (inc && !dec) begin
        m4 = (m4 < 3) ? m4 + 1 : 3;
        mr = (mr < 3) ? mr + 1 : 3;
        m5 = (m5 < 4) ? m5 + 1 : 4;
      end else if (dec && !inc) begin
        m4 = (m4 > 0) ? m4 - 1 : 0;
        mr = (mr > 0) ? mr - 1 : 0;
        m5 = (m5 > 0) ? m5 - 1 : 0;
      end
      tick(inc, dec);
      checks += 3;
      if (count4 !== 2'(m4)) begin errors++; $display("FAIL rand_w4 cyc%0d: got %0d expected %0d", n, count4, m4); end
      if (countr !== 2'(mr)) begin errors++; $display("FAIL rand_r2 cyc%0d: got %0d expected %0d", n, countr, mr); end
      if (count5 !== 3'(m5)) begin errors++; $display("FAIL rand_w5 cyc%0d: got %0d expected %0d", n, count5, m5); end
`ifdef SATURATING_COUNTER_FLAGS_EN
      checks += 2;
      if (is_min5 !== (m5 == 0)) begin errors++; $display("FAIL rand_w5_is_min cyc%0d: got %0b expected %0b", n, is_min5, (m5 == 0)); end
      if (is_max5 !== (m5 == 4)) begin errors++; $display("FAIL rand_w5_is_max cyc%0d: got %0b expected %0b", n, is_max5, (m5 == 4)); end
`endif
    end
  endtask

  initial begin
    errors    = 0;
    checks    = 0;
    resetn    = 1'b1;
    increment = 1'b0;
    decrement = 1'b0;
    @(negedge clock);
    test_reset();
    test_increment();
    test_decrement();
    test_simultaneous();
    test_async_reset();
    test_width5();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/saturating_up_down_counter.md
# saturating_up_down_counter

Synchronous up/down counter over the range 0..WIDTH-1 that saturates at both ends instead of wrapping. It is a generic building block for branch-predictor confidence counters, credit and occupancy trackers, and hysteresis filters. It holds one registered count value that changes by at most one step per clock cycle.

## Interface
Parameters:
- `WIDTH`, default 4. Number of counter states. Count range is 0..WIDTH-1. Must be ≥ 2.
- `RESET`, default 0. Value loaded on reset. Must lie in 0..WIDTH-1.

Derived: `WIDTH_LOG2 = $clog2(WIDTH)`, the width of `count`.

Ports:
- `clock`, input, 1 bit. Single clock; all state updates on its rising edge.
- `resetn`, input, 1 bit. Reset is asynchronous and active-low.
- `increment`, input, 1 bit. Request a +1 step this cycle.
- `decrement`, input, 1 bit. Request a −1 step this cycle.
- `count`, output, WIDTH_LOG2 bits. Current counter value, driven directly from the state register.
- `is_min`, output, 1 bit. High when `count` is 0. Present only with `SATURATING_COUNTER_FLAGS_EN`.
- `is_max`, output, 1 bit. High when `count` is WIDTH-1. Present only with `SATURATING_COUNTER_FLAGS_EN`.

## Operation
Next-state rules, evaluated at each rising clock edge while `resetn` is high:
- `increment`=1, `decrement`=0: count+1 if count < WIDTH-1, else hold at WIDTH-1.
- `increment`=0, `decrement`=1: count−1 if count > 0, else hold at 0.
- Both 0: hold.
- Both 1: hold. Requests cancel; this is not an error.

Further rules:
- The counter never wraps. Saturated requests are silently ignored; no error output exists.
- When WIDTH is not a power of two, encodings ≥ WIDTH are unreachable. The comparisons use WIDTH-1 explicitly, not all-ones.
- Compute arithmetic at WIDTH_LOG2 bits. The guard comparisons prevent overflow and underflow.

## Timing
- Reset: when `resetn` falls, `count` becomes RESET immediately, without waiting for a clock edge. It stays RESET while `resetn` is low; requests are ignored during reset.
- Reset release: the first rising edge with `resetn`=1 samples requests normally. Reset may be asserted at any point mid-operation, with the same immediate effect.
- Latency: one cycle. A request sampled at edge N is visible on `count` after edge N, and is stable by the following falling edge.
- Throughput: one step per cycle. A request held high for k cycles moves `count` by min(k, distance to the bound).
- No handshake: `increment` and `decrement` are level-sampled on each rising edge.
- `is_min` and `is_max` are combinational decodes of the registered `count`. They have zero added latency and their reset values follow RESET.

## Configuration
- Macro: `SATURATING_COUNTER_FLAGS_EN`.
- Defined: the `is_min` and `is_max` ports exist and behave as specified above.
- Undefined: these ports and their logic are absent. Counting behaviour is identical in both builds.

## Test plan
1. Reset value: WIDTH=4, RESET=0. Pulse `resetn` low, release, wait one clock → `count`=0 (`is_min`=1 when the flags build is enabled).
2. Increment and saturation: from 0, hold `increment`=1 for 5 cycles → `count` reads 1, 2, 3, 3, 3. Never 0 after 3. `is_max`=1 from the third step.
3. Decrement and saturation: from 3, hold `decrement`=1 for 5 cycles → `count` reads 2, 1, 0, 0, 0. Never 3 after 0.
4. Simultaneous requests: at `count`=2, drive `increment`=`decrement`=1 for 3 cycles → `count` stays 2.
5. Asynchronous reset mid-count: with RESET=2, count up to 3, then drop `resetn` between clock edges → `count`=2 before the next rising edge. Release reset, increment once → 3.
6. Random: 100 cycles of random `increment`/`decrement` → `count` matches a reference model clamped to 0..3 every cycle. Repeat with WIDTH=5 (3-bit count; values 5–7 are never seen).
